sample_serializer: RTL

- Parallel-in, serial-out feeder for the FFT input path. Drives the serial input of the downstream serial-in right-shift register.
- Accepts parallel samples on a valid/ready handshake and buffers one word.
- Shifts each word out LSB-first, one bit per clock, so the downstream register holds the word in its original bit order after width shifts.
- Supports gap-free back-to-back words and a last-bit strobe for word framing.

---
 rtl/sample_serializer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sample_serializer.sv
// sample_serializer: parallel-in, serial-out feeder for the FFT input path.
// Accepts a sample word on a valid/ready handshake into a one-entry hold
// buffer, then shifts it out LSB-first, one bit per clock, with s_en marking
// valid bits and last marking the final (MSB) bit of each word.
//
// Ports:
//   clk        system clock, rising edge
//   clr        synchronous active-high clear
//   din        parallel sample word
//   din_valid  din carries a word this cycle
//   din_ready  hold buffer can take din this cycle
//   s_out      serial data bit (to downstream s_in)
//   s_en       s_out is a valid bit this cycle
//   last       s_out is the MSB of the current word
//   busy       a word is shifting or waiting in the hold buffer
module sample_serializer #(
  parameter int unsigned width = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [width-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             s_out,
  output logic             s_en,
  output logic             last,
  output logic             busy
);

  localparam int unsigned CNT_W = (width > 1) ? $clog2(width) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(width - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [width-1:0]   r_hold;
  logic               r_hold_full;
  logic [width-1:0]   r_shreg;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic               w_last_bit;
  logic               w_load;

  // Final bit of the word currently on s_out.
  assign w_last_bit = (r_state == ST_SHIFT) && (r_cnt == CNT_LAST);
  assign w_accept   = din_valid & din_ready;
  // Hold entry moves to the shifter when idle, or seamlessly on the last bit.
  assign w_load     = r_hold_full & ((r_state == ST_IDLE) | w_last_bit);

  // State register.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_hold_full) begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last_bit && !r_hold_full) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from registered state; din_ready also masks the clear cycle.
  always_comb begin
    s_out     = 1'b0;
    s_en      = 1'b0;
    last      = 1'b0;
    busy      = r_hold_full;
    din_ready = ~r_hold_full & ~clr;
    if (r_state == ST_SHIFT) begin
      s_out = r_shreg[0];
      s_en  = 1'b1;
      last  = w_last_bit;
      busy  = 1'b1;
    end
  end

  // Hold buffer, shifter and bit counter. Accept and load never coincide:
  // accept needs an empty hold entry, load needs a full one.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shreg     <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_accept) begin
        r_hold      <= din;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end

      if (w_load) begin
        r_shreg <= r_hold;
        r_cnt   <= '0;
      end else if (r_state == ST_SHIFT) begin
        r_shreg <= r_shreg >> 1;
        r_cnt   <= w_last_bit ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

endmodule
